// File: rtl/iq_sample_player.sv
// RAM-backed IQ stimulus source: load {I,Q} pairs in IDLE, replay them as AXI-stream beats in PLAY.
// Optional stall_cycles counter is built when IQ_PLAYER_STALL_CNT_EN is defined.
module iq_sample_player #(
    parameter int ADDR_W = 10,
    parameter int IQ_W   = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load_valid,
    input  logic [IQ_W-1:0]     load_i,
    input  logic [IQ_W-1:0]     load_q,
    output logic                load_ready,
    input  logic                load_clear,
    output logic [ADDR_W:0]     sample_count,
    input  logic                start,
    input  logic                abort,
    input  logic [15:0]         spp,
    input  logic [15:0]         loop_count,
    output logic [2*IQ_W-1:0]   m_axis_tdata,
    output logic                m_axis_tvalid,
    output logic                m_axis_tlast,
    input  logic                m_axis_tready,
`ifdef IQ_PLAYER_STALL_CNT_EN
    output logic [31:0]         stall_cycles,
`endif
    output logic                busy,
    output logic                done
);
    localparam int DEPTH = 2**ADDR_W;
    localparam int DW    = 2*IQ_W;
    localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE  = (ADDR_W+1)'(1);

    typedef enum logic {IDLE, PLAY} state_t;
    state_t state;

    logic [DW-1:0]      mem [DEPTH];
    logic [ADDR_W:0]    count;
    logic [ADDR_W-1:0]  rd_ptr;
    logic [15:0]        pkt_cnt, pass_cnt, spp_lat, loop_lat;
    logic               issue_stop, abort_pend;

    // Read-data stage plus a two-entry output queue (out + skid).
    logic               rq_vld, rq_last, rq_final;
    logic [DW-1:0]      ram_q;
    logic               out_vld, out_last, out_final;
    logic [DW-1:0]      out_data;
    logic               skid_vld, skid_last, skid_final;
    logic [DW-1:0]      skid_data;

    logic               idle, go, pop, wr_en, issue, stop_play;
    logic [ADDR_W-1:0]  cur_ptr;
    logic [15:0]        cur_pkt, cur_pass, cur_spp, cur_loop;
    logic               last_pass, beat_last, beat_final;
    logic [1:0]         occ;

    assign idle         = (state == IDLE);
    assign load_ready   = idle && (count < FULL) && !start;
    assign wr_en        = load_valid && load_ready && !load_clear;
    assign go           = idle && start && (count != '0);
    assign pop          = out_vld && m_axis_tready;
    assign sample_count = count;
    assign m_axis_tdata = out_data;
    assign m_axis_tvalid = out_vld;
    assign m_axis_tlast = out_last;

    // On the start cycle the first read is issued with freshly cleared counters.
    assign cur_ptr  = idle ? '0    : rd_ptr;
    assign cur_pkt  = idle ? '0    : pkt_cnt;
    assign cur_pass = idle ? '0    : pass_cnt;
    assign cur_spp  = idle ? spp   : spp_lat;
    assign cur_loop = idle ? loop_count : loop_lat;

    // Packet/pass position is fixed by sequence order, so tlast is decided at issue time.
    assign last_pass  = ({1'b0, cur_ptr} == count - ONE);
    assign beat_last  = last_pass || ((cur_spp != '0) && (cur_pkt + 16'd1 == cur_spp));
    assign beat_final = last_pass && (cur_loop != '0) && (cur_pass + 16'd1 == cur_loop);

    assign occ   = 2'(out_vld) + 2'(skid_vld) + 2'(rq_vld);
    assign issue = go || (!idle && !issue_stop && (occ - 2'(pop) <= 2'd1));
    assign stop_play = !idle && ((pop && out_final) ||
                                 ((abort_pend || abort) && (!out_vld || pop)));

    always_ff @(posedge clk) begin
        if (wr_en) mem[count[ADDR_W-1:0]] <= {load_i, load_q};
        if (issue) ram_q <= mem[cur_ptr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            rd_ptr     <= '0;
            pkt_cnt    <= '0;
            pass_cnt   <= '0;
            spp_lat    <= '0;
            loop_lat   <= '0;
            issue_stop <= 1'b0;
            abort_pend <= 1'b0;
            rq_vld     <= 1'b0;
            rq_last    <= 1'b0;
            rq_final   <= 1'b0;
            out_vld    <= 1'b0;
            out_last   <= 1'b0;
            out_final  <= 1'b0;
            out_data   <= '0;
            skid_vld   <= 1'b0;
            skid_last  <= 1'b0;
            skid_final <= 1'b0;
            skid_data  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (idle) begin
                if (load_clear && !start) count <= '0;
                else if (wr_en)           count <= count + ONE;
                if (start) begin
                    spp_lat    <= spp;
                    loop_lat   <= loop_count;
                    rd_ptr     <= '0;
                    pkt_cnt    <= '0;
                    pass_cnt   <= '0;
                    issue_stop <= 1'b0;
                    abort_pend <= 1'b0;
                    if (count == '0) begin
                        done <= 1'b1;
                    end else begin
                        state <= PLAY;
                        busy  <= 1'b1;
                    end
                end
            end else if (abort) begin
                abort_pend <= 1'b1;
            end

            if (issue) begin
                rd_ptr   <= last_pass ? '0 : cur_ptr + ADDR_W'(1);
                pkt_cnt  <= beat_last ? '0 : cur_pkt + 16'd1;
                pass_cnt <= cur_pass + 16'(last_pass);
                if (beat_final) issue_stop <= 1'b1;
            end

            rq_vld   <= issue;
            rq_last  <= beat_last;
            rq_final <= beat_final;

            if (!out_vld || pop) begin
                if (skid_vld) begin
                    out_vld    <= 1'b1;
                    out_data   <= skid_data;
                    out_last   <= skid_last;
                    out_final  <= skid_final;
                    skid_vld   <= rq_vld;
                    skid_data  <= ram_q;
                    skid_last  <= rq_last;
                    skid_final <= rq_final;
                end else begin
                    out_vld <= rq_vld;
                    if (rq_vld) begin
                        out_data  <= ram_q;
                        out_last  <= rq_last;
                        out_final <= rq_final;
                    end
                end
            end else if (rq_vld) begin
                skid_vld   <= 1'b1;
                skid_data  <= ram_q;
                skid_last  <= rq_last;
                skid_final <= rq_final;
            end

            // Completion or abort: drop prefetched beats and return to IDLE.
            if (stop_play) begin
                state      <= IDLE;
                busy       <= 1'b0;
                done       <= pop && out_final;
                abort_pend <= 1'b0;
                rq_vld     <= 1'b0;
                out_vld    <= 1'b0;
                out_last   <= 1'b0;
                skid_vld   <= 1'b0;
            end
        end
    end

`ifdef IQ_PLAYER_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (reset)
            stall_cycles <= '0;
        else if (go)
            stall_cycles <= '0;
        else if (!idle && out_vld && !m_axis_tready && (stall_cycles != 32'hFFFF_FFFF))
            stall_cycles <= stall_cycles + 32'd1;
    end
`endif

endmodule

// File: doc/iq_sample_player.md
Name: iq_sample_player

Overview:
- RAM-backed IQ stimulus source: samples are loaded one IQ pair per beat, then replayed on an AXI-stream master as packed {I,Q} words.
- Programmable packet length and loop count.
- Hardware counterpart of the team's file-based IQ sample reader: it emits on-chip the same 16-bit I/Q pairs that the benches read from MATLAB text files, feeding DUT inputs in simulation and on hardware.

Parameters:
ADDR_W, 10, buffer address width; DEPTH = 2**ADDR_W samples
IQ_W, 16, width of each I and Q component (signed)

Ports:
clk  in  1  sole clock
reset  in  1  synchronous, active-high reset
load_valid  in  1  load beat valid
load_i  in  IQ_W  I component to store
load_q  in  IQ_W  Q component to store
load_ready  out  1  high when a load beat can be accepted
load_clear  in  1  discard loaded samples (IDLE only)
sample_count  out  ADDR_W+1  number of samples currently loaded
start  in  1  one-cycle pulse; begin playback (IDLE only)
abort  in  1  stop playback at next beat boundary
spp  in  16  samples per packet; 0 = tlast only at end of each buffer pass
loop_count  in  16  buffer passes; 0 = infinite until abort
m_axis_tdata  out  2*IQ_W  {I, Q}, I in upper half
m_axis_tvalid  out  1  output beat valid
m_axis_tlast  out  1  end of packet
m_axis_tready  in  1  downstream ready
busy  out  1  high in PLAY
done  out  1  one-cycle pulse when playback completes normally

Behaviour:
- One clock; reset is synchronous and active-high.
- On reset, all outputs are 0: tvalid, tlast, tdata, busy, done, sample_count. State goes to IDLE. RAM contents are retained but treated as undefined.
- Reset mid-playback aborts immediately; no tlast is forced.
- States: IDLE, PLAY.
- IDLE behaviour:
  - load_ready = IDLE && sample_count < DEPTH && !start.
  - A beat with load_valid && load_ready writes {load_i, load_q} at address sample_count, then sample_count increments.
  - load_clear sets sample_count to 0 and wins over a simultaneous load beat, which is dropped.
  - When sample_count = DEPTH, load_ready is low and further beats stall.
- start in IDLE:
  - spp and loop_count are latched.
  - Read pointer, packet counter, pass counter and stall counter are cleared.
  - If sample_count = 0: no transition; done pulses the next cycle and no beats are emitted.
  - Otherwise go to PLAY; busy goes high the next cycle.
- start is ignored in PLAY. load_valid and load_clear are ignored in PLAY (load_ready low).
- PLAY, output timing:
  - Synchronous-read RAM plus output register.
  - First tvalid appears 2 cycles after the start cycle.
  - With tready held high, one beat per cycle thereafter (prefetch/skid register required).
- AXI-stream rules:
  - Once tvalid is high, tdata and tlast hold stable until tready.
  - tvalid never drops without a handshake, except on reset.
- Read pointer: increments per handshake and wraps from sample_count-1 to 0. Each wrap completes one pass.
- tlast is asserted on a beat when either holds:
  - the packet counter reaches spp (spp != 0), or
  - the beat is the last sample of a pass.
  In both cases the packet counter resets. A short final packet per pass is therefore allowed.
- Completion:
  - With loop_count = N != 0, after the handshake of the last beat of pass N: go to IDLE, busy drops, done pulses 1 cycle.
  - loop_count = 0 plays forever.
- abort:
  - Latched as a pending flag.
  - Takes effect when tvalid is low, or on the next handshake: no further beats are issued and the state goes to IDLE.
  - done does not pulse. The last beat carries tlast only if it earned it normally.
  - abort in IDLE is ignored.
- The loaded buffer persists across playbacks; restarting replays from sample 0.

Optional Feature:
- Macro: IQ_PLAYER_STALL_CNT_EN.
- When defined:
  - Extra output port stall_cycles (out, 32 bits).
  - Counts cycles with m_axis_tvalid && !m_axis_tready while in PLAY.
  - Saturates at 2^32-1, is cleared on accepted start, holds its value in IDLE, and resets to 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Load 8 pairs (I=k, Q=-k, k=0..7); start with spp=4, loop_count=1, tready=1 → tdata 0x0000_0000, 0x0001_FFFF, ..., tlast on beats 4 and 8; first tvalid 2 cycles after start; done pulses once; sample_count stays 8.
- Load 10 samples, spp=4, loop_count=2 → 20 beats with tlast on beats 4, 8, 10, 14, 18, 20; the data sequence restarts at sample 0 on beat 11.
- Toggle tready with pattern 1,0,0,1,... during playback → no beat lost or duplicated; tdata/tlast stable while stalled; with IQ_PLAYER_STALL_CNT_EN, stall_cycles equals the count of stalled cycles.
- Load DEPTH samples → load_ready low, beat DEPTH+1 not accepted, sample_count = DEPTH; then load_clear together with load_valid → sample_count = 0 and no write occurs.
- loop_count=0, abort asserted after 37 handshakes while tready=0 → the pending beat completes on the next tready, no further tvalid, busy low, no done pulse.
- Start with sample_count=0 → done pulses one cycle later, tvalid never rises; reset asserted mid-PLAY → all outputs 0 the next cycle, state IDLE.
